// File: rtl/mult_accumulator_pkg.sv
`default_nettype none
// ==========================================================================
// mult_accumulator_pkg : shared state encodings and default widths
// Revision 1.0
// ==========================================================================
package mult_accumulator_pkg;

  // Upstream multiplier operands are 4-bit unsigned, so a product fits in 8 bits.
  localparam int unsigned DEF_PROD_W = 8;
  localparam int unsigned DEF_ACC_W  = 12;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mult_accumulator_adder.sv
`default_nettype none
// ==========================================================================
// mult_acc_adder : ACC_W+1 bit add with wrap, or saturate when
//                  MULT_ACC_SATURATE_EN is defined
// Revision 1.0
// ==========================================================================
module mult_acc_adder #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] product_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] w_sum;

  assign w_sum   = {1'b0, acc_i} + {{(ACC_W+1-PROD_W){1'b0}}, product_i};
  assign carry_o = w_sum[ACC_W];

`ifdef MULT_ACC_SATURATE_EN
  // Once pinned at all-ones, every further non-zero add carries again, so it stays saturated.
  assign sum_o = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign sum_o = w_sum[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/mult_accumulator.sv
`default_nettype none
// ==========================================================================
// mult_accumulator : sums BURST products, hands the total off via valid/ready
// Optional saturation: MULT_ACC_SATURATE_EN.  Revision 1.0
// ==========================================================================
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [7:0]        count,
  output logic              overflow
);

  localparam logic [7:0] C_BURST = 8'(BURST);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_last;

  mult_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i     (acc_q),
    .product_i (product),
    .sum_o     (w_sum),
    .carry_o   (w_carry)
  );

  assign w_accept = in_valid && in_ready;
  assign w_last   = (count_q + 8'd1) == C_BURST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (w_accept && w_last) state_d = ST_DONE;
        ST_DONE:  if (out_ready)          state_d = ST_ACCUM;
        default:                          state_d = ST_ACCUM;
      endcase
    end
  end

  // in_ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    in_ready  = rst_n && (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear || (out_valid && out_ready)) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (w_accept) begin
      acc_d   = w_sum;
      count_d = count_q + 8'd1;
      ovf_d   = ovf_q | w_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ==========================================================================
// tb_mult_accumulator : directed vectors, queued expectations, handshake monitor
// Revision 1.0
// ==========================================================================
module tb_mult_accumulator;

  typedef struct {
    logic [11:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

`ifdef MULT_ACC_SATURATE_EN
  localparam logic [11:0] EXP_B20 = 12'd4095;
`else
  localparam logic [11:0] EXP_B20 = 12'd404;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [7:0]  product;
  logic        in_ready, out_valid, overflow;
  logic [11:0] acc_out;
  logic [7:0]  count;

  logic        iv20, or20, ir20, ov20, ovf20;
  logic [11:0] acc20;
  logic [7:0]  cnt20;

  logic        iv1, or1, ir1, ov1, ovf1;
  logic [11:0] acc1;
  logic [7:0]  cnt1;

  logic        c_zero = 1'b0;
  logic [7:0]  p225   = 8'd225;
  logic [7:0]  p6     = 8'd6;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mult_accumulator #(.PROD_W(8), .ACC_W(12), .BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .count(count), .overflow(overflow));

  mult_accumulator #(.PROD_W(8), .ACC_W(12), .BURST(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .clear(c_zero), .in_valid(iv20), .in_ready(ir20),
    .product(p225), .out_valid(ov20), .out_ready(or20),
    .acc_out(acc20), .count(cnt20), .overflow(ovf20));

  mult_accumulator #(.PROD_W(8), .ACC_W(12), .BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(c_zero), .in_valid(iv1), .in_ready(ir1),
    .product(p6), .out_valid(ov1), .out_ready(or1),
    .acc_out(acc1), .count(cnt1), .overflow(ovf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] a, input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    sb_q.push_back(e);
  endtask

  // Returns #1 after the accepting edge, so the new sum is already visible.
  task automatic send(input logic [7:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    product  = p;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 (product %0d)", p);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got result %0d expected none", acc_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_acc", 32'(acc_out), 32'(mon_e.acc));
        chk("sb_cnt", 32'(count), 32'(mon_e.cnt));
        chk("sb_ovf", 32'(overflow), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; product = '0; out_ready = 1'b1;
    iv20 = 1'b0; or20 = 1'b0; iv1 = 1'b0; or1 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_iready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 15+30+45+60 with immediate handoff
    push(12'd150, 8'd4, 1'b0);
    send(8'd15);
    chk("lat_acc", 32'(acc_out), 15);
    chk("lat_cnt", 32'(count), 1);
    send(8'd30); send(8'd45); send(8'd60);
    chk("done_iready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("post_acc", 32'(acc_out), 0);
    chk("post_cnt", 32'(count), 0);
    chk("post_ovalid", 32'(out_valid), 0);
    chk("post_iready", 32'(in_ready), 1);

    // 225 x4 with consumer stalled; extra products must be ignored
    out_ready = 1'b0;
    push(12'd900, 8'd4, 1'b0);
    repeat (4) send(8'd225);
    in_valid = 1'b1;
    product  = 8'd99;
    repeat (5) begin
      @(negedge clk);
      chk("stall_iready", 32'(in_ready), 0);
      chk("stall_acc", 32'(acc_out), 900);
      chk("stall_ovalid", 32'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_iready", 32'(in_ready), 1);
    chk("rel_acc", 32'(acc_out), 0);

    // clear drops the product presented with it
    send(8'd9); send(8'd12);
    in_valid = 1'b1; product = 8'd49; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_acc", 32'(acc_out), 0);
    chk("clr_cnt", 32'(count), 0);
    push(12'd10, 8'd4, 1'b0);
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);

    // async reset mid-burst
    send(8'd5); send(8'd6); send(8'd7);
    chk("pre_rst_acc", 32'(acc_out), 18);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", 32'(acc_out), 0);
    chk("arst_cnt", 32'(count), 0);
    chk("arst_iready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_iready", 32'(in_ready), 1);

    // BURST=20 of 225 overflows the 12-bit sum
    iv20 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ov20 && n < 100) begin
      @(negedge clk);
      n++;
    end
    iv20 = 1'b0;
    chk("b20_valid", 32'(ov20), 1);
    chk("b20_acc", 32'(acc20), 32'(EXP_B20));
    chk("b20_ovf", 32'(ovf20), 1);
    chk("b20_cnt", 32'(cnt20), 20);
    or20 = 1'b1;
    @(posedge clk); #1;
    chk("b20_clr_ovf", 32'(ovf20), 0);
    chk("b20_clr_acc", 32'(acc20), 0);

    // BURST=1 with in_valid held: result every other cycle
    iv1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b1_ovalid", 32'(ov1), 32'(i % 2));
      if (i % 2 == 1) begin
        chk("b1_acc", 32'(acc1), 6);
        chk("b1_cnt", 32'(cnt1), 1);
      end
    end
    iv1 = 1'b0;

    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
